writeback_stage: RTL

//  Final pipeline stage of the RV32I core. Directly upstream of the integer register file.

---
 rtl/writeback_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Final RV32I pipeline stage: retires instructions into the register file,
// waits for load data, extends it, counts retirements and flags response faults.
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 200,
    parameter int TMO_W        = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wb_valid_in,
    output logic        wb_ready_out,
    input  logic [4:0]  wb_rd_addr_in,
    input  logic        wb_rd_en_in,
    input  logic        wb_is_load_in,
    input  logic [2:0]  wb_funct3_in,
    input  logic [1:0]  wb_addr_lsb_in,
    input  logic [31:0] wb_result_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    output logic        wr_en_out,
    output logic        load_busy_out,
    output logic [31:0] instret_out,
    output logic        spurious_err_out,
    output logic        timeout_err_out
);

    typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [4:0]        rd_addr_reg, rd_addr_next;
    logic [31:0]       rd_data_reg, rd_data_next;
    logic              wr_en_reg, wr_en_next;
    logic [31:0]       instret_reg, instret_next;
    logic              spurious_reg, spurious_next;
    logic              timeout_reg, timeout_next;
    logic [4:0]        ld_rd_reg, ld_rd_next;
    logic              ld_rd_en_reg, ld_rd_en_next;
    logic [2:0]        ld_funct3_reg, ld_funct3_next;
    logic [1:0]        ld_lsb_reg, ld_lsb_next;
    logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic              accept;

    // Byte/halfword selection and extension; reserved encodings fall back to LW.
    function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                                input logic [1:0] lsb,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (lsb)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lsb[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b100:  extend_load = {24'd0, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b101:  extend_load = {16'd0, h};
            default: extend_load = d;
        endcase
    endfunction

    assign accept = wb_valid_in && (state_reg == IDLE);

    always_comb begin
        state_next     = state_reg;
        rd_addr_next   = rd_addr_reg;
        rd_data_next   = rd_data_reg;
        wr_en_next     = 1'b0;
        instret_next   = instret_reg;
        spurious_next  = spurious_reg;
        timeout_next   = timeout_reg;
        ld_rd_next     = ld_rd_reg;
        ld_rd_en_next  = ld_rd_en_reg;
        ld_funct3_next = ld_funct3_reg;
        ld_lsb_next    = ld_lsb_reg;
        tmo_cnt_next   = tmo_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (dmem_rvalid_in)
                    spurious_next = 1'b1;
                if (accept) begin
                    if (wb_is_load_in) begin
                        ld_rd_next     = wb_rd_addr_in;
                        ld_rd_en_next  = wb_rd_en_in;
                        ld_funct3_next = wb_funct3_in;
                        ld_lsb_next    = wb_addr_lsb_in;
                        tmo_cnt_next   = '0;
                        state_next     = WAIT_LOAD;
                    end else begin
                        instret_next = instret_reg + 32'd1;
                        if (wb_rd_en_in && (wb_rd_addr_in != 5'd0)) begin
                            wr_en_next   = 1'b1;
                            rd_addr_next = wb_rd_addr_in;
                            rd_data_next = wb_result_in;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                // A response on the final timeout cycle still completes the load.
                if (dmem_rvalid_in) begin
                    state_next   = IDLE;
                    instret_next = instret_reg + 32'd1;
                    if (ld_rd_en_reg && (ld_rd_reg != 5'd0)) begin
                        wr_en_next   = 1'b1;
                        rd_addr_next = ld_rd_reg;
                        rd_data_next = extend_load(ld_funct3_reg, ld_lsb_reg, dmem_rdata_in);
                    end
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            rd_addr_reg   <= '0;
            rd_data_reg   <= '0;
            wr_en_reg     <= 1'b0;
            instret_reg   <= '0;
            spurious_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
            ld_rd_reg     <= '0;
            ld_rd_en_reg  <= 1'b0;
            ld_funct3_reg <= '0;
            ld_lsb_reg    <= '0;
            tmo_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            rd_addr_reg   <= rd_addr_next;
            rd_data_reg   <= rd_data_next;
            wr_en_reg     <= wr_en_next;
            instret_reg   <= instret_next;
            spurious_reg  <= spurious_next;
            timeout_reg   <= timeout_next;
            ld_rd_reg     <= ld_rd_next;
            ld_rd_en_reg  <= ld_rd_en_next;
            ld_funct3_reg <= ld_funct3_next;
            ld_lsb_reg    <= ld_lsb_next;
            tmo_cnt_reg   <= tmo_cnt_next;
        end
    end

    assign wb_ready_out     = (state_reg == IDLE);
    assign load_busy_out    = (state_reg == WAIT_LOAD);
    assign rd_addr_out      = rd_addr_reg;
    assign rd_out           = rd_data_reg;
    assign wr_en_out        = wr_en_reg;
    assign instret_out      = instret_reg;
    assign spurious_err_out = spurious_reg;
    assign timeout_err_out  = timeout_reg;

endmodule
